// File: rtl/ff_serial_tx.sv
// rtl/ff_serial_tx.sv - parallel-in, serial-out frame transmitter
//
// Purpose:
//   Captures a WIDTH-bit word and sends it on a single line as a frame of
//   start bit (0), data LSB first, stop bit (1). Each bit lasts DIV enabled
//   clock cycles. A global enable freezes all state, as in a bank of
//   enabled registers.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous reset, active-high
//   enable  in   global clock enable; 0 holds all state
//   load    in   frame start request, taken only in IDLE with enable=1
//   D       in   parallel word, captured on the accepting edge
//   Y       out  serial line, idles high
//   busy    out  high while a frame is in progress
//   ready   out  high in IDLE (~busy)
//   done    out  one-cycle pulse on the edge that ends the stop bit

module ff_serial_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic             Y,
  output logic             busy,
  output logic             ready,
  output logic             done
);

  localparam int BW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bitcnt;
  logic [7:0]       r_div;
  logic             r_done;

  // Last enabled cycle of the current bit period.
  logic w_bit_end;
  assign w_bit_end = (r_div == 8'(DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_div    <= '0;
      r_done   <= 1'b0;
    end else begin
      // done is a strict one-clock pulse, even when enable drops right after.
      r_done <= 1'b0;
      if (enable) begin
        case (r_state)
          S_IDLE: begin
            if (load) begin
              r_shift <= D;
              r_div   <= '0;
              r_state <= S_START;
            end
          end
          S_START: begin
            if (w_bit_end) begin
              r_div    <= '0;
              r_bitcnt <= '0;
              r_state  <= S_DATA;
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_div    <= '0;
              r_shift  <= r_shift >> 1;
              r_bitcnt <= r_bitcnt + BW'(1);
              if (r_bitcnt == BW'(WIDTH - 1)) begin
                r_state <= S_STOP;
              end
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          S_STOP: begin
            if (w_bit_end) begin
              r_div   <= '0;
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Line level is decoded from state so that reset forces it high at once.
  assign Y     = (r_state == S_DATA) ? r_shift[0] : (r_state != S_START);
  assign busy  = (r_state != S_IDLE);
  assign ready = (r_state == S_IDLE);
  assign done  = r_done;

endmodule

// File: tb/tb_ff_serial_tx.sv
// tb/tb_ff_serial_tx.sv - directed self-checking bench for ff_serial_tx

module tb_ff_serial_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       load1 = 1'b0;
  logic       load2 = 1'b0;
  logic [3:0] D = 4'b0000;
  logic       y1, busy1, ready1, done1;
  logic       y2, busy2, ready2, done2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ff_serial_tx #(.WIDTH(4), .DIV(1)) u_dut1 (
    .clock (clock), .reset (reset), .enable (enable), .load (load1), .D (D),
    .Y (y1), .busy (busy1), .ready (ready1), .done (done1)
  );

  ff_serial_tx #(.WIDTH(4), .DIV(2)) u_dut2 (
    .clock (clock), .reset (reset), .enable (enable), .load (load2), .D (D),
    .Y (y2), .busy (busy2), .ready (ready2), .done (done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check n consecutive line samples (exp read MSB first = time order) while busy.
  task automatic expect_y(input string tag, input int sel, input logic [15:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_y[%0d]", tag, i), (sel == 2) ? y2 : y1, exp[n-1-i]);
      check($sformatf("%s_busy[%0d]", tag, i), (sel == 2) ? busy2 : busy1, 1'b1);
      if (i < n - 1) tick();
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    // Reset pulse at t=2..4
    #2 reset = 1'b1;
    #1;
    check("rst_y", y1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_ready", ready1, 1'b1);
    check("rst_done", done1, 1'b0);
    #1 reset = 1'b0;
    tick();
    tick();
    check("idle_y", y1, 1'b1);
    check("idle_busy", busy1, 1'b0);
    check("idle_ready", ready1, 1'b1);
    check("idle_y2", y2, 1'b1);

    // Single frame, DIV=1, D=1011
    D = 4'b1011; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    check("single_ready", ready1, 1'b0);
    expect_y("single", 1, 16'b011011, 6);
    tick();
    check("single_done", done1, 1'b1);
    check("single_ready_end", ready1, 1'b1);
    check("single_y_end", y1, 1'b1);
    tick();
    check("single_done_clr", done1, 1'b0);

    // Enable gating during data bit 1
    D = 4'b1011; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    check("gate_y0", y1, 1'b0);
    tick();
    check("gate_y1", y1, 1'b1);
    tick();
    check("gate_y2", y1, 1'b1);
    enable = 1'b0;
    tick();
    check("gate_y3", y1, 1'b1);
    check("gate_busy3", busy1, 1'b1);
    tick();
    check("gate_y4", y1, 1'b1);
    enable = 1'b1;
    tick();
    check("gate_y5", y1, 1'b0);
    tick();
    check("gate_y6", y1, 1'b1);
    tick();
    check("gate_y7", y1, 1'b1);
    check("gate_busy7", busy1, 1'b1);
    tick();
    check("gate_done", done1, 1'b1);
    enable = 1'b0;
    tick();
    check("gate_done_clr", done1, 1'b0);
    check("gate_idle", ready1, 1'b1);
    enable = 1'b1;

    // Load while busy is ignored
    D = 4'b1111; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    check("rej_y0", y1, 1'b0);
    tick();
    D = 4'b0000; load1 = 1'b1;
    expect_y("rej", 1, 16'b11111, 5);
    load1 = 1'b0;
    tick();
    check("rej_done", done1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rej_nobusy[%0d]", i), busy1, 1'b0);
      check($sformatf("rej_idle_y[%0d]", i), y1, 1'b1);
    end

    // Back-to-back with DIV=2
    do_reset();
    D = 4'b0101; load2 = 1'b1;
    tick();
    load2 = 1'b0;
    expect_y("b2b_a", 2, 16'b001100110011, 12);
    tick();
    check("b2b_done", done2, 1'b1);
    check("b2b_ready", ready2, 1'b1);
    D = 4'b1001; load2 = 1'b1;
    tick();
    load2 = 1'b0;
    D = 4'b0000;
    expect_y("b2b_b", 2, 16'b001100001111, 12);
    tick();
    check("b2b_done2", done2, 1'b1);
    tick();
    check("b2b_idle", busy2, 1'b0);

    // Reset in the middle of data bit 1
    D = 4'b1111; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    tick();
    tick();
    check("mid_busy_pre", busy1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_y", y1, 1'b1);
    check("mid_busy", busy1, 1'b0);
    check("mid_ready", ready1, 1'b1);
    #1 reset = 1'b0;
    tick();
    check("mid_post_busy", busy1, 1'b0);
    D = 4'b0110; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    expect_y("mid_frame", 1, 16'b001101, 6);
    tick();
    check("mid_done", done1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
